// File: rtl/fmac_result_buf_if.sv
// fmac_result_buf_if: producer/consumer handshake and status signals of the FMAC result buffer.
interface fmac_result_buf_if #(
    parameter int C_DEPTH     = 2,
    parameter int C_TAG_WIDTH = 4,
    parameter int C_RES_WIDTH = 32
);
    localparam int C_CNT_WIDTH = $clog2(C_DEPTH + 1);
    logic                   Valid_SI;
    logic                   Ready_SO;
    logic [C_RES_WIDTH-1:0] Result_DI;
    logic                   Exp_OF_SI;
    logic                   Exp_UF_SI;
    logic [C_TAG_WIDTH-1:0] Tag_DI;
    logic                   Flush_SI;
    logic                   Valid_SO;
    logic                   Ready_SI;
    logic [C_RES_WIDTH-1:0] Result_DO;
    logic [C_TAG_WIDTH-1:0] Tag_DO;
    logic [1:0]             Flags_DO;
    logic                   Clr_flags_SI;
    logic [1:0]             Sticky_DO;
    logic [C_CNT_WIDTH-1:0] Count_DO;
    modport slave (
        input  Valid_SI, Result_DI, Exp_OF_SI, Exp_UF_SI, Tag_DI, Flush_SI, Ready_SI, Clr_flags_SI,
        output Ready_SO, Valid_SO, Result_DO, Tag_DO, Flags_DO, Sticky_DO, Count_DO
    );
    modport master (
        output Valid_SI, Result_DI, Exp_OF_SI, Exp_UF_SI, Tag_DI, Flush_SI, Ready_SI, Clr_flags_SI,
        input  Ready_SO, Valid_SO, Result_DO, Tag_DO, Flags_DO, Sticky_DO, Count_DO
    );
endinterface

// File: rtl/fmac_result_buf.sv
// fmac_result_buf: FIFO of FMAC results with tags, valid/ready output and sticky OF/UF status.
module fmac_result_buf #(
    parameter int C_DEPTH     = 2,
    parameter int C_TAG_WIDTH = 4,
    parameter int C_RES_WIDTH = 32
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    fmac_result_buf_if.slave  b
);
    localparam int C_AW        = $clog2(C_DEPTH);
    localparam int C_CNT_WIDTH = $clog2(C_DEPTH + 1);
    logic [C_AW:0]          r_wptr, r_rptr;
    logic [C_RES_WIDTH-1:0] r_res [C_DEPTH];
    logic [C_TAG_WIDTH-1:0] r_tag [C_DEPTH];
    logic [1:0]             r_flg [C_DEPTH];
    logic [1:0]             r_sticky;
    logic [C_AW-1:0]        w_widx, w_ridx;
    logic [C_AW:0]          w_diff;
    logic                   w_full, w_empty, w_push, w_pop;
    logic [1:0]             w_head_flg;
    assign w_widx     = r_wptr[C_AW-1:0];
    assign w_ridx     = r_rptr[C_AW-1:0];
    assign w_full     = (w_widx == w_ridx) && (r_wptr[C_AW] != r_rptr[C_AW]);
    assign w_empty    = r_wptr == r_rptr;
    assign w_push     = b.Valid_SI && !w_full && !b.Flush_SI;
    assign w_pop      = !w_empty && b.Ready_SI && !b.Flush_SI;
    assign w_head_flg = r_flg[w_ridx];
    assign w_diff     = r_wptr - r_rptr;
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (b.Flush_SI) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end
    // Clear wins over accumulation, but a flag retired in the same cycle survives the clear.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI)              r_sticky <= '0;
        else if (b.Clr_flags_SI) r_sticky <= w_pop ? w_head_flg : 2'b00;
        else if (w_pop)          r_sticky <= r_sticky | w_head_flg;
    end
    always_ff @(posedge Clk_CI) begin
        if (w_push) begin
            r_res[w_widx] <= b.Result_DI;
            r_tag[w_widx] <= b.Tag_DI;
            r_flg[w_widx] <= {b.Exp_OF_SI, b.Exp_UF_SI};
        end
    end
    assign b.Ready_SO  = !w_full;
    assign b.Valid_SO  = !w_empty;
    assign b.Result_DO = w_empty ? '0 : r_res[w_ridx];
    assign b.Tag_DO    = w_empty ? '0 : r_tag[w_ridx];
    assign b.Flags_DO  = w_empty ? 2'b00 : w_head_flg;
    assign b.Sticky_DO = r_sticky;
    assign b.Count_DO  = C_CNT_WIDTH'(w_diff);
    // A stalled offer must keep its payload until it is accepted or withdrawn.
    a_stable_payload: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
        (b.Valid_SI && !b.Ready_SO) |=> (!b.Valid_SI || ($stable(b.Result_DI) && $stable(b.Tag_DI))));
endmodule

// File: tb/tb_fmac_result_buf.sv
// tb_fmac_result_buf: directed scenario tests of fmac_result_buf with hand-computed expectations.
module tb_fmac_result_buf;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    fmac_result_buf_if #(.C_DEPTH(2), .C_TAG_WIDTH(4), .C_RES_WIDTH(32)) b ();
    fmac_result_buf #(.C_DEPTH(2), .C_TAG_WIDTH(4), .C_RES_WIDTH(32)) dut (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .b      (b)
    );
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic offer(input logic v, input logic [31:0] res, input logic [3:0] tag, input logic [1:0] flg);
        b.Valid_SI  = v;
        b.Result_DI = res;
        b.Tag_DI    = tag;
        {b.Exp_OF_SI, b.Exp_UF_SI} = flg;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        offer(1'b1, 32'hDEADBEEF, 4'd7, 2'b11);
        b.Ready_SI = 1'b1;
        repeat (3) cyc();
        n_chk++; if (b.Valid_SO !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", b.Valid_SO); end
        n_chk++; if (b.Count_DO !== 2'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", b.Count_DO); end
        n_chk++; if (b.Sticky_DO !== 2'b00) begin n_fail++; $display("FAIL rst_sticky: got %b want 00", b.Sticky_DO); end
        n_chk++; if (b.Ready_SO !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", b.Ready_SO); end
        rst = 1'b0;
        offer(1'b0, 32'h0, 4'd0, 2'b00);
        b.Ready_SI = 1'b0;
        cyc();
        n_chk++; if (b.Valid_SO !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %0b want 0", b.Valid_SO); end
        n_chk++; if (b.Count_DO !== 2'd0) begin n_fail++; $display("FAIL post_rst_count: got %0d want 0", b.Count_DO); end
        n_chk++; if (b.Ready_SO !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %0b want 1", b.Ready_SO); end
        n_chk++; if (b.Result_DO !== 32'h0) begin n_fail++; $display("FAIL post_rst_result: got %h want 0", b.Result_DO); end
    endtask
    task automatic test_hold();
        b.Ready_SI = 1'b0;
        offer(1'b1, 32'h3F800000, 4'd1, 2'b00);
        cyc();
        offer(1'b0, 32'h12345678, 4'd9, 2'b11);
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (b.Valid_SO !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %0b want 1", i, b.Valid_SO); end
            n_chk++; if (b.Result_DO !== 32'h3F800000) begin n_fail++; $display("FAIL hold_result[%0d]: got %h want 3f800000", i, b.Result_DO); end
            n_chk++; if (b.Tag_DO !== 4'd1) begin n_fail++; $display("FAIL hold_tag[%0d]: got %0d want 1", i, b.Tag_DO); end
            n_chk++; if (b.Count_DO !== 2'd1) begin n_fail++; $display("FAIL hold_count[%0d]: got %0d want 1", i, b.Count_DO); end
            if (i < 2) cyc();
        end
        b.Ready_SI = 1'b1;
        cyc();
        b.Ready_SI = 1'b0;
        n_chk++; if (b.Count_DO !== 2'd0) begin n_fail++; $display("FAIL pop_count: got %0d want 0", b.Count_DO); end
        n_chk++; if (b.Valid_SO !== 1'b0) begin n_fail++; $display("FAIL pop_valid: got %0b want 0", b.Valid_SO); end
        n_chk++; if (b.Tag_DO !== 4'd0) begin n_fail++; $display("FAIL empty_tag: got %0d want 0", b.Tag_DO); end
    endtask
    task automatic test_full();
        b.Ready_SI = 1'b0;
        offer(1'b1, 32'hA, 4'd2, 2'b00);
        cyc();
        offer(1'b1, 32'hB, 4'd3, 2'b00);
        cyc();
        n_chk++; if (b.Count_DO !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d want 2", b.Count_DO); end
        n_chk++; if (b.Ready_SO !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", b.Ready_SO); end
        offer(1'b1, 32'hC, 4'd4, 2'b00);
        cyc();
        n_chk++; if (b.Count_DO !== 2'd2) begin n_fail++; $display("FAIL full_reject_count: got %0d want 2", b.Count_DO); end
        n_chk++; if (b.Tag_DO !== 4'd2) begin n_fail++; $display("FAIL full_head_tag: got %0d want 2", b.Tag_DO); end
        b.Ready_SI = 1'b1;
        cyc();
        b.Valid_SI = 1'b0;
        n_chk++; if (b.Count_DO !== 2'd1) begin n_fail++; $display("FAIL full_pop_count: got %0d want 1", b.Count_DO); end
        n_chk++; if (b.Ready_SO !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %0b want 1", b.Ready_SO); end
        n_chk++; if (b.Tag_DO !== 4'd3) begin n_fail++; $display("FAIL full_pop_tag: got %0d want 3", b.Tag_DO); end
        cyc();
        b.Ready_SI = 1'b0;
        n_chk++; if (b.Valid_SO !== 1'b0) begin n_fail++; $display("FAIL full_drain_valid: got %0b want 0", b.Valid_SO); end
    endtask
    task automatic test_back_to_back();
        b.Ready_SI = 1'b1;
        offer(1'b1, 32'h100, 4'd0, 2'b00);
        cyc();
        n_chk++; if (b.Count_DO !== 2'd1) begin n_fail++; $display("FAIL b2b_first_count: got %0d want 1", b.Count_DO); end
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, 32'h100 + 32'(i), 4'(i), 2'b00);
            n_chk++; if (b.Tag_DO !== 4'(i - 1)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, b.Tag_DO, i - 1); end
            n_chk++; if (b.Count_DO !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, b.Count_DO); end
            cyc();
        end
        b.Valid_SI = 1'b0;
        n_chk++; if (b.Tag_DO !== 4'd8) begin n_fail++; $display("FAIL b2b_last_tag: got %0d want 8", b.Tag_DO); end
        n_chk++; if (b.Result_DO !== 32'h108) begin n_fail++; $display("FAIL b2b_last_result: got %h want 108", b.Result_DO); end
        cyc();
        b.Ready_SI = 1'b0;
        n_chk++; if (b.Count_DO !== 2'd0) begin n_fail++; $display("FAIL b2b_drain_count: got %0d want 0", b.Count_DO); end
    endtask
    task automatic test_sticky();
        b.Ready_SI = 1'b0;
        offer(1'b1, 32'h7F800000, 4'd5, 2'b10);
        cyc();
        offer(1'b1, 32'h00000000, 4'd6, 2'b01);
        cyc();
        b.Valid_SI = 1'b0;
        n_chk++; if (b.Flags_DO !== 2'b10) begin n_fail++; $display("FAIL head_flags: got %b want 10", b.Flags_DO); end
        n_chk++; if (b.Sticky_DO !== 2'b00) begin n_fail++; $display("FAIL sticky_pre: got %b want 00", b.Sticky_DO); end
        b.Ready_SI = 1'b1;
        cyc();
        n_chk++; if (b.Sticky_DO !== 2'b10) begin n_fail++; $display("FAIL sticky_of: got %b want 10", b.Sticky_DO); end
        cyc();
        b.Ready_SI = 1'b0;
        n_chk++; if (b.Sticky_DO !== 2'b11) begin n_fail++; $display("FAIL sticky_ofuf: got %b want 11", b.Sticky_DO); end
        offer(1'b1, 32'h1, 4'd7, 2'b01);
        cyc();
        b.Valid_SI = 1'b0;
        b.Clr_flags_SI = 1'b1;
        b.Ready_SI = 1'b1;
        cyc();
        b.Ready_SI = 1'b0;
        n_chk++; if (b.Sticky_DO !== 2'b01) begin n_fail++; $display("FAIL clr_with_pop: got %b want 01", b.Sticky_DO); end
        cyc();
        b.Clr_flags_SI = 1'b0;
        n_chk++; if (b.Sticky_DO !== 2'b00) begin n_fail++; $display("FAIL clr_no_pop: got %b want 00", b.Sticky_DO); end
        offer(1'b1, 32'h2, 4'd8, 2'b10);
        cyc();
        b.Valid_SI = 1'b0;
        b.Ready_SI = 1'b1;
        cyc();
        b.Ready_SI = 1'b0;
        n_chk++; if (b.Sticky_DO !== 2'b10) begin n_fail++; $display("FAIL sticky_reload: got %b want 10", b.Sticky_DO); end
    endtask
    task automatic test_flush();
        b.Ready_SI = 1'b0;
        offer(1'b1, 32'hAA, 4'd10, 2'b01);
        cyc();
        offer(1'b1, 32'hBB, 4'd11, 2'b01);
        cyc();
        n_chk++; if (b.Count_DO !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 2", b.Count_DO); end
        offer(1'b1, 32'hCC, 4'd12, 2'b11);
        b.Flush_SI = 1'b1;
        b.Ready_SI = 1'b1;
        cyc();
        b.Flush_SI = 1'b0;
        b.Valid_SI = 1'b0;
        b.Ready_SI = 1'b0;
        n_chk++; if (b.Count_DO !== 2'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", b.Count_DO); end
        n_chk++; if (b.Valid_SO !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", b.Valid_SO); end
        n_chk++; if (b.Sticky_DO !== 2'b10) begin n_fail++; $display("FAIL flush_sticky: got %b want 10", b.Sticky_DO); end
        n_chk++; if (b.Ready_SO !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", b.Ready_SO); end
        cyc();
        n_chk++; if (b.Count_DO !== 2'd0) begin n_fail++; $display("FAIL flush_dropped: got %0d want 0", b.Count_DO); end
    endtask
    initial begin
        b.Flush_SI     = 1'b0;
        b.Clr_flags_SI = 1'b0;
        b.Ready_SI     = 1'b0;
        test_reset();
        test_hold();
        test_full();
        test_back_to_back();
        test_sticky();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
